// File: rtl/pulse_gen_if.sv
// pulse_gen_if: groups the trigger, configuration and status signals of
// the pulse train generator.
//   master modport : drives trig_i, abort_i, delay_i, width_i, num_i;
//                    observes sig_o, busy_o, done_o
//   slave modport  : the generator side (mirror of master)
// Parameters CNT_W / NUM_W must match those of the attached pulse_gen.
interface pulse_gen_if #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 4
);
    logic             trig_i;
    logic             abort_i;
    logic [CNT_W-1:0] delay_i;
    logic [CNT_W-1:0] width_i;
    logic [NUM_W-1:0] num_i;
    logic             sig_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output trig_i, abort_i, delay_i, width_i, num_i,
        input  sig_o, busy_o, done_o
    );

    modport slave (
        input  trig_i, abort_i, delay_i, width_i, num_i,
        output sig_o, busy_o, done_o
    );
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse train generator. A rising edge on trig_i
// starts a sequence of delay_i idle cycles followed by num_i pulses, each
// width_i cycles high and separated by width_i-cycle gaps (width 0 acts as 1).
// busy_o is high while the sequence runs, done_o strobes for one cycle on
// normal completion. abort_i cancels a running sequence without done_o.
//
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - pulse_gen_if.slave: trig_i, abort_i, delay_i, width_i, num_i
//            in; sig_o, busy_o, done_o out (all outputs registered)
//
// Build option:
//   PULSE_GEN_TRIG_SYNC_EN - when defined, trig_i passes a two-flop
//   synchronizer before edge detection (adds 2 cycles of trigger latency).
module pulse_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pulse_gen_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        HIGH,
        GAP,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] w_q, w_nx;
    logic [NUM_W-1:0] n_q, n_nx;
    logic             trig_s;
    logic             trig_d;
    logic             rise;

    // A zero width would never let the phase counter reach 1.
    function automatic logic [CNT_W-1:0] min_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

`ifdef PULSE_GEN_TRIG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.trig_i};
        end
    end

    assign trig_s = sync_q[1];
`else
    assign trig_s = bus.trig_i;
`endif

    assign rise = trig_s & ~trig_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            w_q        <= '0;
            n_q        <= '0;
            trig_d     <= 1'b0;
            bus.sig_o  <= 1'b0;
            bus.busy_o <= 1'b0;
            bus.done_o <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            w_q        <= w_nx;
            n_q        <= n_nx;
            trig_d     <= trig_s;
            // Outputs are decoded from the next state so they line up with
            // the state register instead of trailing it by a cycle.
            bus.sig_o  <= (state_nx == HIGH);
            bus.busy_o <= (state_nx == DELAY) || (state_nx == HIGH) ||
                          (state_nx == GAP);
            bus.done_o <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        w_nx     = w_q;
        n_nx     = n_q;
        case (state)
            IDLE: begin
                if (rise) begin
                    w_nx = min_one(bus.width_i);
                    n_nx = bus.num_i;
                    if (bus.num_i == '0) begin
                        state_nx = DONE;
                    end else if (bus.delay_i == '0) begin
                        state_nx = HIGH;
                        cnt_nx   = min_one(bus.width_i);
                    end else begin
                        state_nx = DELAY;
                        cnt_nx   = bus.delay_i;
                    end
                end
            end
            DELAY: begin
                if (cnt == CNT_W'(1)) begin
                    state_nx = HIGH;
                    cnt_nx   = w_q;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt == CNT_W'(1)) begin
                    n_nx = n_q - NUM_W'(1);
                    if (n_q == NUM_W'(1)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = GAP;
                        cnt_nx   = w_q;
                    end
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(1)) begin
                    state_nx = HIGH;
                    cnt_nx   = w_q;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Abort wins over everything, including a rise seen in IDLE.
        if (bus.abort_i) begin
            state_nx = IDLE;
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed testbench for pulse_gen. A vector table holds
// per-sequence settings with hand-computed sig/busy/done waveforms (bit k =
// output value after clock edge T+k, T being the trigger edge); hand-written
// sequences cover reset, max delay/count, abort+trigger and reset mid-run.
module tb_pulse_gen;

`ifdef PULSE_GEN_TRIG_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pulse_gen_if #(.CNT_W(8), .NUM_W(4)) bus ();

    pulse_gen #(.CNT_W(8), .NUM_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [7:0]  w;
        logic [3:0]  n;
        int          ab_k;    // abort high during cycle after sample k (-1: none)
        int          rt_k;    // re-raise trig after sample k (-1: none)
        logic [15:0] e_sig;
        logic [15:0] e_busy;
        logic [15:0] e_done;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [23:0] a_sig, a_busy, a_done;
        logic [23:0] x_sig, x_busy, x_done;
        a_sig  = '0;
        a_busy = '0;
        a_done = '0;
        repeat (4) @(negedge clk);
        bus.delay_i = v.d;
        bus.width_i = v.w;
        bus.num_i   = v.n;
        bus.trig_i  = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            a_sig[k]  = bus.sig_o;
            a_busy[k] = bus.busy_o;
            a_done[k] = bus.done_o;
            if (k == 0) bus.trig_i = 1'b0;
            if (k == 2) begin
                // configuration must have been latched by now
                bus.delay_i = 8'hAA;
                bus.width_i = 8'h55;
                bus.num_i   = 4'h9;
            end
            if (v.ab_k >= 0 && k == v.ab_k + LAT)     bus.abort_i = 1'b1;
            if (v.ab_k >= 0 && k == v.ab_k + LAT + 1) bus.abort_i = 1'b0;
            if (v.rt_k >= 0 && k == v.rt_k + LAT)     bus.trig_i  = 1'b1;
        end
        bus.trig_i  = 1'b0;
        bus.abort_i = 1'b0;
        x_sig  = {8'h00, v.e_sig}  << LAT;
        x_busy = {8'h00, v.e_busy} << LAT;
        x_done = {8'h00, v.e_done} << LAT;
        chk($sformatf("vec%0d sig", idx),  32'(a_sig),  32'(x_sig));
        chk($sformatf("vec%0d busy", idx), 32'(a_busy), 32'(x_busy));
        chk($sformatf("vec%0d done", idx), 32'(a_done), 32'(x_done));
    endtask

    initial begin
        int first_hi;
        int hi_cnt;
        int done_k;

        tests = 0;
        fails = 0;

        //                d      w      n     ab  rt   sig       busy      done
        vecs[0] = '{8'd3, 8'd2, 4'd1, -1, -1, 16'h0018, 16'h001F, 16'h0020}; // basic
        vecs[1] = '{8'd0, 8'd1, 4'd3, -1, -1, 16'h0015, 16'h001F, 16'h0020}; // train
        vecs[2] = '{8'd0, 8'd0, 4'd3, -1, -1, 16'h0015, 16'h001F, 16'h0020}; // width 0
        vecs[3] = '{8'd5, 8'd3, 4'd0, -1, -1, 16'h0000, 16'h0000, 16'h0001}; // num 0
        vecs[4] = '{8'd1, 8'd3, 4'd2, -1, -1, 16'h038E, 16'h03FF, 16'h0400};
        vecs[5] = '{8'd2, 8'd1, 4'd2, -1, -1, 16'h0014, 16'h001F, 16'h0020};
        vecs[6] = '{8'd0, 8'd3, 4'd2, -1,  1, 16'h01C7, 16'h01FF, 16'h0200}; // retrigger
        vecs[7] = '{8'd0, 8'd4, 4'd2,  1, -1, 16'h0003, 16'h0003, 16'h0000}; // abort HIGH
        vecs[8] = '{8'd4, 8'd2, 4'd1,  1, -1, 16'h0000, 16'h0003, 16'h0000}; // abort DELAY

        rst         = 1'b1;
        bus.trig_i  = 1'b0;
        bus.abort_i = 1'b0;
        bus.delay_i = 8'd0;
        bus.width_i = 8'd1;
        bus.num_i   = 4'd1;

        // reset held 50 ns with trig toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("reset hold %0d", i),
                {29'd0, bus.sig_o, bus.busy_o, bus.done_o}, 32'd0);
            bus.trig_i = ~bus.trig_i;
        end
        bus.trig_i = 1'b0;
        rst        = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post reset %0d", i),
                {29'd0, bus.sig_o, bus.busy_o, bus.done_o}, 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // maximum delay and pulse count: d=255, w=1, n=15
        repeat (4) @(negedge clk);
        bus.delay_i = 8'd255;
        bus.width_i = 8'd1;
        bus.num_i   = 4'd15;
        bus.trig_i  = 1'b1;
        first_hi = -1;
        hi_cnt   = 0;
        done_k   = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            bus.trig_i = 1'b0;
            if (bus.sig_o) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = k;
            end
            if (bus.done_o) begin
                done_k = k;
                break;
            end
        end
        chk("max first high", 32'(first_hi), 32'(255 + LAT));
        chk("max pulse count", 32'(hi_cnt), 32'd15);
        chk("max done cycle", 32'(done_k), 32'(255 + 29 + LAT));

        // abort together with a trigger edge: nothing starts
        repeat (4) @(negedge clk);
        bus.delay_i = 8'd0;
        bus.width_i = 8'd2;
        bus.num_i   = 4'd1;
        bus.trig_i  = 1'b1;
        bus.abort_i = 1'b1;
        repeat (4) @(negedge clk);
        bus.abort_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("abort+trig %0d", i),
                {29'd0, bus.sig_o, bus.busy_o, bus.done_o}, 32'd0);
        end
        bus.trig_i = 1'b0;

        // reset pulsed for 20 ns in the GAP phase of d=0, w=4, n=2
        repeat (4) @(negedge clk);
        bus.delay_i = 8'd0;
        bus.width_i = 8'd4;
        bus.num_i   = 4'd2;
        bus.trig_i  = 1'b1;
        for (int k = 0; k <= 5 + LAT; k++) begin
            @(negedge clk);
            bus.trig_i = 1'b0;
        end
        chk("mid gap state", {30'd0, bus.sig_o, bus.busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async reset", {29'd0, bus.sig_o, bus.busy_o, bus.done_o}, 32'd0);
        #19;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("after gap reset %0d", i),
                {29'd0, bus.sig_o, bus.busy_o, bus.done_o}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
